// File: rtl/eae_unit.sv
// Extended arithmetic element: sequential multiply, divide, normalise and
// shifts on the {AC,MQ} register pair, one step per clock.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; MQ may be loaded through mq_wr
// RUN   | one shift/add/subtract step per cycle, down-counter running
// DONE  | result registers final, done pulses for this one cycle
module eae_unit #(
    parameter int WIDTH = 12,
    parameter int SCW   = $clog2(2*WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ac_in,
    input  logic             link_in,
    input  logic [WIDTH-1:0] operand,
    input  logic             mq_wr,
    input  logic [WIDTH-1:0] mq_din,
    output logic [WIDTH-1:0] ac_out,
    output logic             link_out,
    output logic [WIDTH-1:0] mq_out,
    output logic [SCW-1:0]   sc_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_MUY = 3'b001;
    localparam logic [2:0] OP_DVI = 3'b010;
    localparam logic [2:0] OP_NMI = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_ASR = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;

    localparam logic [SCW-1:0] MAX_SHIFT = SCW'(2*WIDTH);
    localparam logic [SCW-1:0] WORD_N    = SCW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ac_reg, mq_reg, opnd_r;
    logic             link_reg, busy_reg, done_reg;
    logic [SCW-1:0]   sc_reg, cnt;
    logic [2:0]       op_r;

    // accept-time decode
    logic [WIDTH-1:0] mq_eff;
    logic [SCW-1:0]   shift_n, acc_n;
    logic             acc_link, nmi_done_in;

    // per-step datapath
    logic [WIDTH:0]   mul_sum, div_rem;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_ac, step_mq;
    logic             step_link, is_shift, nmi_stop, last_step;

    // Decode iteration count and initial link for the operation being accepted.
    always_comb begin
        mq_eff      = mq_wr ? mq_din : mq_reg;
        shift_n     = (operand[SCW-1:0] > MAX_SHIFT) ? MAX_SHIFT : operand[SCW-1:0];
        nmi_done_in = (ac_in[WIDTH-1] != ac_in[WIDTH-2]) || ({ac_in, mq_eff} == '0);
        acc_link    = link_in;
        acc_n       = '0;
        case (op)
            OP_MUY: begin
                acc_n    = WORD_N;
                acc_link = 1'b0;
            end
            OP_DVI: begin
                if (ac_in >= operand) begin
                    acc_link = 1'b1;
                end else begin
                    acc_n    = WORD_N;
                    acc_link = 1'b0;
                end
            end
            OP_NMI: begin
                // the limit is the backstop; the normalise test ends it earlier
                if (!nmi_done_in) acc_n = MAX_SHIFT;
            end
            OP_SHL: acc_n = shift_n;
            OP_ASR: begin
                acc_n    = shift_n;
                acc_link = ac_in[WIDTH-1];
            end
            OP_LSR: begin
                acc_n    = shift_n;
                acc_link = 1'b0;
            end
            default: ;
        endcase
    end

    // One iteration of the latched operation on the current {AC,MQ}.
    always_comb begin
        mul_sum   = {1'b0, ac_reg} + (mq_reg[0] ? {1'b0, opnd_r} : '0);
        div_rem   = {ac_reg, mq_reg[WIDTH-1]};
        div_ge    = div_rem >= {1'b0, opnd_r};
        div_diff  = div_rem[WIDTH-1:0] - opnd_r;
        step_ac   = ac_reg;
        step_mq   = mq_reg;
        step_link = link_reg;
        is_shift  = 1'b0;
        case (op_r)
            OP_MUY: begin
                step_ac = mul_sum[WIDTH:1];
                step_mq = {mul_sum[0], mq_reg[WIDTH-1:1]};
            end
            OP_DVI: begin
                step_ac = div_ge ? div_diff : div_rem[WIDTH-1:0];
                step_mq = {mq_reg[WIDTH-2:0], div_ge};
            end
            OP_NMI: begin
                step_ac  = {ac_reg[WIDTH-2:0], mq_reg[WIDTH-1]};
                step_mq  = {mq_reg[WIDTH-2:0], 1'b0};
                is_shift = 1'b1;
            end
            OP_SHL: begin
                step_link = ac_reg[WIDTH-1];
                step_ac   = {ac_reg[WIDTH-2:0], mq_reg[WIDTH-1]};
                step_mq   = {mq_reg[WIDTH-2:0], 1'b0};
                is_shift  = 1'b1;
            end
            OP_ASR: begin
                step_ac  = {ac_reg[WIDTH-1], ac_reg[WIDTH-1:1]};
                step_mq  = {ac_reg[0], mq_reg[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            OP_LSR: begin
                step_ac  = {1'b0, ac_reg[WIDTH-1:1]};
                step_mq  = {ac_reg[0], mq_reg[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            default: ;
        endcase
        nmi_stop  = (step_ac[WIDTH-1] != step_ac[WIDTH-2]) || ({step_ac, step_mq} == '0);
        last_step = (cnt == SCW'(1)) || ((op_r == OP_NMI) && nmi_stop);
    end

    // Control FSM with the result registers and registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ac_reg   <= '0;
            mq_reg   <= '0;
            link_reg <= 1'b0;
            sc_reg   <= '0;
            cnt      <= '0;
            op_r     <= '0;
            opnd_r   <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ac_reg   <= ac_in;
                        mq_reg   <= mq_eff;
                        link_reg <= acc_link;
                        sc_reg   <= '0;
                        op_r     <= op;
                        opnd_r   <= operand;
                        cnt      <= acc_n;
                        busy_reg <= 1'b1;
                        if (acc_n == '0) begin
                            state    <= DONE;
                            done_reg <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else if (mq_wr) begin
                        mq_reg <= mq_din;
                    end
                end
                RUN: begin
                    ac_reg   <= step_ac;
                    mq_reg   <= step_mq;
                    link_reg <= step_link;
                    if (is_shift) sc_reg <= sc_reg + SCW'(1);
                    cnt <= cnt - SCW'(1);
                    if (last_step) begin
                        state    <= DONE;
                        done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ac_out   = ac_reg;
    assign mq_out   = mq_reg;
    assign link_out = link_reg;
    assign sc_out   = sc_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
